// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_pkg
//  Description : Shared types and helpers for the unified-memory port
//                arbiter. It holds the arbiter state encoding, the bit
//                positions inside the decoder's one-hot storecntrl/loadcntrl
//                fields, and the access-size, byte-enable, alignment and
//                lane-replication helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_D_BUSY  = 2'd1,
        S_IF_BUSY = 2'd2,
        S_D_ERR   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // storecntrl = {sw, sh, sb}
    localparam int c_st_sb = 0;
    localparam int c_st_sh = 1;
    localparam int c_st_sw = 2;

    // loadcntrl = {lhu, lbu, lw, lh, lb}
    localparam int c_ld_lb  = 0;
    localparam int c_ld_lh  = 1;
    localparam int c_ld_lw  = 2;
    localparam int c_ld_lbu = 3;
    localparam int c_ld_lhu = 4;

    // An all-zero (illegal) control field falls through to a word access.
    function automatic acc_size_t acc_size(input logic       we,
                                           input logic [2:0] st,
                                           input logic [4:0] ld);
        acc_size_t sz;
        sz = SZ_WORD;
        if (we) begin
            if (st[c_st_sb])      sz = SZ_BYTE;
            else if (st[c_st_sh]) sz = SZ_HALF;
            else if (st[c_st_sw]) sz = SZ_WORD;
        end else begin
            if (ld[c_ld_lb] || ld[c_ld_lbu])      sz = SZ_BYTE;
            else if (ld[c_ld_lh] || ld[c_ld_lhu]) sz = SZ_HALF;
            else if (ld[c_ld_lw])                 sz = SZ_WORD;
        end
        return sz;
    endfunction

    // Loads always read the full word, so only stores narrow the enables.
    function automatic logic [3:0] byte_en(input logic      we,
                                           input acc_size_t sz,
                                           input logic [1:0] lo);
        logic [3:0] be;
        be = 4'b1111;
        if (we) begin
            if (sz == SZ_BYTE)      be = 4'b0001 << lo;
            else if (sz == SZ_HALF) be = 4'b0011 << {lo[1], 1'b0};
        end
        return be;
    endfunction

    function automatic logic is_misaligned(input acc_size_t  sz,
                                           input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if (sz == SZ_HALF)      mis = lo[0];
        else if (sz == SZ_WORD) mis = (lo != 2'b00);
        return mis;
    endfunction

    // Replicating narrow store data across all lanes lets the byte enables
    // alone pick the destination lane.
    function automatic logic [31:0] lane_replicate(input acc_size_t   sz,
                                                   input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (sz == SZ_BYTE)      r = {4{d[7:0]}};
        else if (sz == SZ_HALF) r = {2{d[15:0]}};
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load-lane selection and extension.
//                Selects the byte/halfword addressed by addr_lo from the
//                memory word and sign- or zero-extends it per loadcntrl.
//                lw and an all-zero loadcntrl pass the word through.
//  Ports       : rdata     in  32  raw memory word
//                addr_lo   in  2   byte offset of the access
//                loadcntrl in  5   one-hot {lhu,lbu,lw,lh,lb}
//                data      out 32  aligned, extended load data
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align
    import riscv_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [4:0]  loadcntrl,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (addr_lo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        if (loadcntrl[c_ld_lb])       data = {{24{w_byte[7]}}, w_byte};
        else if (loadcntrl[c_ld_lbu]) data = {24'd0, w_byte};
        else if (loadcntrl[c_ld_lh])  data = {{16{w_half[15]}}, w_half};
        else if (loadcntrl[c_ld_lhu]) data = {16'd0, w_half};
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported memory between instruction fetch
//                and MEM-stage data accesses. Data wins over fetch. Each
//                access is one registered m_req transaction closed by
//                m_ready; the ack is combinational in the m_ready cycle.
//                Misaligned data accesses are rejected without touching
//                memory. A flush during a fetch lets the bus transaction
//                finish but drops its ack.
//  Options     : `define ARB_TIMEOUT_EN to abort transactions whose m_ready
//                wait reaches TIMEOUT_CYCLES (ack with bus_err=1, zero data).
//  Ports       : clk, reset (async, active-high)
//                if_req/if_addr -> if_rdata/if_ack            fetch port
//                flush                                        fetch cancel
//                d_req/d_we/d_addr/d_wdata/d_storecntrl/d_loadcntrl
//                    -> d_rdata/d_ack/d_misalign              data port
//                bus_err, stall_if, stall_d                   status
//                m_req/m_we/m_addr/m_be/m_wdata, m_rdata/m_ready  memory
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              flush,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_storecntrl,
    input  logic [4:0]        d_loadcntrl,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              d_misalign,
    output logic              bus_err,
    output logic              stall_if,
    output logic              stall_d,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    input  logic              m_ready
);

    arb_state_t        r_state, w_state_nxt;
    logic              r_m_req, r_m_we, r_drop;
    logic [ADDR_W-1:0] r_m_addr;
    logic [3:0]        r_m_be;
    logic [31:0]       r_m_wdata;
    logic [1:0]        r_addr_lo;
    logic [4:0]        r_loadcntrl;

    acc_size_t   w_d_size;
    logic        w_d_bad;
    logic        w_grant_d, w_grant_if, w_complete, w_tmo, w_tmo_arm;
    logic        w_if_ack, w_d_ack, w_misalign, w_bus_err;
    logic [31:0] w_load_data;

    assign w_d_size = acc_size(d_we, d_storecntrl, d_loadcntrl);
    assign w_d_bad  = is_misaligned(w_d_size, d_addr[1:0]);

`ifdef ARB_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_tmo_w-1:0] r_tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tmo_cnt <= '0;
        else if (w_grant_d || w_grant_if)
            r_tmo_cnt <= '0;
        else if (r_m_req && !m_ready)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

    // m_req is withdrawn on the edge the count reaches the limit; the
    // following cycle (m_req low, count at limit) delivers the error ack.
    assign w_tmo_arm = r_m_req && !m_ready
                       && (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYCLES - 1));
    assign w_tmo     = !r_m_req && (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYCLES));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_tmo_arm    = 1'b0;
    assign w_tmo        = 1'b0;
`endif

    assign w_complete = (r_m_req && m_ready) || w_tmo;

    always_comb begin
        w_state_nxt = r_state;
        w_grant_d   = 1'b0;
        w_grant_if  = 1'b0;
        w_if_ack    = 1'b0;
        w_d_ack     = 1'b0;
        w_misalign  = 1'b0;
        w_bus_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (d_req) begin
                    if (w_d_bad) begin
                        w_state_nxt = S_D_ERR;
                    end else begin
                        w_state_nxt = S_D_BUSY;
                        w_grant_d   = 1'b1;
                    end
                end else if (if_req && !flush) begin
                    w_state_nxt = S_IF_BUSY;
                    w_grant_if  = 1'b1;
                end
            end
            S_D_BUSY: begin
                if (w_complete) begin
                    w_d_ack     = 1'b1;
                    w_bus_err   = w_tmo;
                    w_state_nxt = S_IDLE;
                end
            end
            S_IF_BUSY: begin
                if (w_complete) begin
                    // A flush seen now or earlier in this fetch drops the ack.
                    w_if_ack    = !(r_drop || flush);
                    w_bus_err   = w_tmo && w_if_ack;
                    w_state_nxt = S_IDLE;
                end
            end
            S_D_ERR: begin
                w_d_ack     = 1'b1;
                w_misalign  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_m_req     <= 1'b0;
            r_m_we      <= 1'b0;
            r_m_addr    <= '0;
            r_m_be      <= 4'd0;
            r_m_wdata   <= 32'd0;
            r_addr_lo   <= 2'd0;
            r_loadcntrl <= 5'd0;
            r_drop      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_grant_d) begin
                r_m_req     <= 1'b1;
                r_m_we      <= d_we;
                r_m_addr    <= {d_addr[ADDR_W-1:2], 2'b00};
                r_m_be      <= byte_en(d_we, w_d_size, d_addr[1:0]);
                r_m_wdata   <= lane_replicate(w_d_size, d_wdata);
                r_addr_lo   <= d_addr[1:0];
                r_loadcntrl <= d_loadcntrl;
            end else if (w_grant_if) begin
                r_m_req  <= 1'b1;
                r_m_we   <= 1'b0;
                r_m_addr <= {if_addr[ADDR_W-1:2], 2'b00};
                r_m_be   <= 4'b1111;
            end else if ((r_m_req && m_ready) || w_tmo_arm) begin
                r_m_req <= 1'b0;
                r_m_we  <= 1'b0;
                r_m_be  <= 4'd0;
            end

            if (r_state == S_IDLE)
                r_drop <= 1'b0;
            else if (r_state == S_IF_BUSY && flush)
                r_drop <= 1'b1;
        end
    end

    load_align u_load_align (
        .rdata     (m_rdata),
        .addr_lo   (r_addr_lo),
        .loadcntrl (r_loadcntrl),
        .data      (w_load_data)
    );

    // if_addr is word aligned by contract; its low bits carry no information.
    logic w_unused_if_lo;
    assign w_unused_if_lo = ^if_addr[1:0];

    assign if_ack     = w_if_ack;
    assign d_ack      = w_d_ack;
    assign d_misalign = w_misalign;
    assign bus_err    = w_bus_err;
    assign if_rdata   = (w_if_ack && !w_bus_err) ? m_rdata : 32'd0;
    assign d_rdata    = (w_d_ack && !w_misalign && !w_bus_err) ? w_load_data : 32'd0;
    assign stall_if   = if_req && !w_if_ack;
    assign stall_d    = d_req && !w_d_ack;
    assign m_req      = r_m_req;
    assign m_we       = r_m_we;
    assign m_addr     = r_m_addr;
    assign m_be       = r_m_be;
    assign m_wdata    = r_m_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Directed self-checking bench for mem_port_arbiter. Inputs
//                change 1 time unit after the rising edge; outputs are
//                checked 1 unit later, well away from the next edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, flush, d_req, d_we, m_ready;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [2:0]  d_storecntrl;
    logic [4:0]  d_loadcntrl;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_ack, d_ack, d_misalign, bus_err, stall_if, stall_d, m_req, m_we;
    logic [3:0]  m_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .flush(flush),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_storecntrl(d_storecntrl), .d_loadcntrl(d_loadcntrl),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_misalign(d_misalign),
        .bus_err(bus_err), .stall_if(stall_if), .stall_d(stall_d),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_be(m_be),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = 0; flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        d_storecntrl = 0; d_loadcntrl = 0;
        m_rdata = 0; m_ready = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({m_req, m_we, m_be, if_ack, d_ack, d_misalign, bus_err} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0", {m_req, m_we, m_be, if_ack, d_ack, d_misalign, bus_err});
        end
        checks++;
        if ({m_addr, m_wdata, if_rdata, d_rdata} !== 128'd0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h if_rdata=%h d_rdata=%h required all 0",
                     m_addr, m_wdata, if_rdata, d_rdata);
        end
    endtask

    task automatic test_store_sb();
        d_req = 1; d_we = 1; d_addr = 32'h103; d_wdata = 32'hAB; d_storecntrl = 3'b001; m_ready = 1;
        #1;
        checks++;
        if ({m_req, d_ack, stall_d} !== 3'b001) begin
            errors++;
            $display("FAIL sb_req_cycle: got m_req,d_ack,stall_d=%b required 001", {m_req, d_ack, stall_d});
        end
        tick(); #1;
        checks++;
        if ({m_req, m_we, m_be, m_addr} !== {1'b1, 1'b1, 4'b1000, 32'h100}) begin
            errors++;
            $display("FAIL sb_bus: got req=%b we=%b be=%b addr=%h required 1 1 1000 00000100", m_req, m_we, m_be, m_addr);
        end
        checks++;
        if (m_wdata !== 32'hABABABAB) begin
            errors++;
            $display("FAIL sb_wdata: got %h required abababab", m_wdata);
        end
        checks++;
        if ({d_ack, d_misalign, bus_err, stall_d} !== 4'b1000) begin
            errors++;
            $display("FAIL sb_ack: got ack,mis,err,stall=%b required 1000", {d_ack, d_misalign, bus_err, stall_d});
        end
        tick();
        d_req = 0; #1;
        checks++;
        if ({m_req, d_ack} !== 2'b00) begin
            errors++;
            $display("FAIL sb_idle: got m_req,d_ack=%b required 00", {m_req, d_ack});
        end
    endtask

    task automatic test_store_narrow();
        logic [31:0] t_addr [3];
        logic [31:0] t_wd   [3];
        logic [2:0]  t_st   [3];
        logic [3:0]  t_be   [3];
        logic [31:0] t_mw   [3];
        t_addr = '{32'h102, 32'h104, 32'h101};
        t_wd   = '{32'h1234BEEF, 32'hCAFEF00D, 32'h0000005A};
        t_st   = '{3'b010, 3'b000, 3'b001};
        t_be   = '{4'b1100, 4'b1111, 4'b0010};
        t_mw   = '{32'hBEEFBEEF, 32'hCAFEF00D, 32'h5A5A5A5A};
        m_ready = 1;
        for (int i = 0; i < 3; i++) begin
            d_req = 1; d_we = 1; d_addr = t_addr[i]; d_wdata = t_wd[i]; d_storecntrl = t_st[i];
            tick(); #1;
            checks++;
            if ({d_ack, m_we, m_be, m_wdata, m_addr} !== {1'b1, 1'b1, t_be[i], t_mw[i], t_addr[i] & 32'hFFFF_FFFC}) begin
                errors++;
                $display("FAIL store_%0d: got ack=%b we=%b be=%b wdata=%h addr=%h required 1 1 %b %h %h",
                         i, d_ack, m_we, m_be, m_wdata, m_addr, t_be[i], t_mw[i], t_addr[i] & 32'hFFFF_FFFC);
            end
            tick();
        end
        d_req = 0; d_storecntrl = 0;
        tick();
    endtask

    task automatic test_load_align();
        logic [31:0] t_addr [8];
        logic [4:0]  t_ld   [8];
        logic [31:0] t_exp  [8];
        t_addr = '{32'h202, 32'h202, 32'h201, 32'h203, 32'h203, 32'h200, 32'h200, 32'h204};
        t_ld   = '{5'b00010, 5'b10000, 5'b00001, 5'b00001, 5'b01000, 5'b00100, 5'b00010, 5'b00000};
        t_exp  = '{32'hFFFF8001, 32'h00008001, 32'h00000012, 32'hFFFFFF80,
                   32'h00000080, 32'h80011234, 32'h00001234, 32'h80011234};
        m_rdata = 32'h8001_1234; m_ready = 1; d_we = 0;
        for (int i = 0; i < 8; i++) begin
            d_req = 1; d_addr = t_addr[i]; d_loadcntrl = t_ld[i];
            tick(); #1;
            checks++;
            if ({d_rdata, d_ack, m_we, m_be, d_misalign} !== {t_exp[i], 1'b1, 1'b0, 4'b1111, 1'b0}) begin
                errors++;
                $display("FAIL load_%0d: got rdata=%h ack=%b we=%b be=%b mis=%b required %h 1 0 1111 0",
                         i, d_rdata, d_ack, m_we, m_be, d_misalign, t_exp[i]);
            end
            tick();
        end
        d_req = 0; d_loadcntrl = 0;
        tick();
    endtask

    task automatic test_misalign();
        logic [31:0] t_addr [4];
        logic        t_we   [4];
        logic [2:0]  t_st   [4];
        logic [4:0]  t_ld   [4];
        t_addr = '{32'h6, 32'h101, 32'h3, 32'h2};
        t_we   = '{1'b0, 1'b1, 1'b0, 1'b1};
        t_st   = '{3'b000, 3'b010, 3'b000, 3'b100};
        t_ld   = '{5'b00100, 5'b00000, 5'b10000, 5'b00000};
        m_rdata = 32'h5555_AAAA; m_ready = 1;
        for (int i = 0; i < 4; i++) begin
            d_req = 1; d_we = t_we[i]; d_addr = t_addr[i]; d_storecntrl = t_st[i]; d_loadcntrl = t_ld[i];
            tick(); #1;
            checks++;
            if ({d_ack, d_misalign, m_req, bus_err, d_rdata} !== {4'b1100, 32'd0}) begin
                errors++;
                $display("FAIL misalign_%0d: got ack=%b mis=%b m_req=%b err=%b rdata=%h required 1 1 0 0 0",
                         i, d_ack, d_misalign, m_req, bus_err, d_rdata);
            end
            d_req = 0;
            tick();
            checks++;
            if ({m_req, d_ack} !== 2'b00) begin
                errors++;
                $display("FAIL misalign_after_%0d: got m_req,d_ack=%b required 00", i, {m_req, d_ack});
            end
        end
        d_we = 0; d_storecntrl = 0; d_loadcntrl = 0;
    endtask

    task automatic test_priority();
        if_req = 1; if_addr = 32'h400;
        d_req = 1; d_we = 0; d_addr = 32'h10; d_loadcntrl = 5'b00100; m_ready = 0;
        #1;
        checks++;
        if ({stall_if, stall_d} !== 2'b11) begin
            errors++;
            $display("FAIL prio_stall0: got %b required 11", {stall_if, stall_d});
        end
        tick(); #1;
        checks++;
        if ({m_req, m_we, m_addr, stall_if, if_ack} !== {2'b10, 32'h10, 2'b10}) begin
            errors++;
            $display("FAIL prio_grant: got req=%b we=%b addr=%h stall_if=%b if_ack=%b required 1 0 00000010 1 0",
                     m_req, m_we, m_addr, stall_if, if_ack);
        end
        tick();
        m_ready = 1; m_rdata = 32'h1111_2222; #1;
        checks++;
        if ({d_ack, d_rdata, if_ack, stall_if} !== {1'b1, 32'h11112222, 2'b01}) begin
            errors++;
            $display("FAIL prio_dack: got d_ack=%b rdata=%h if_ack=%b stall_if=%b required 1 11112222 0 1",
                     d_ack, d_rdata, if_ack, stall_if);
        end
        tick();
        d_req = 0; d_loadcntrl = 0; m_rdata = 32'h3333_4444; #1;
        checks++;
        if ({m_req, stall_if} !== 2'b01) begin
            errors++;
            $display("FAIL prio_gap: got m_req,stall_if=%b required 01", {m_req, stall_if});
        end
        tick(); #1;
        checks++;
        if ({m_addr, if_ack, if_rdata, stall_if, d_ack, bus_err} !== {32'h400, 1'b1, 32'h33334444, 3'b000}) begin
            errors++;
            $display("FAIL prio_fetch: got addr=%h if_ack=%b rdata=%h stall_if=%b d_ack=%b err=%b required 00000400 1 33334444 0 0 0",
                     m_addr, if_ack, if_rdata, stall_if, d_ack, bus_err);
        end
        if_req = 0;
        tick();
    endtask

    task automatic test_flush();
        if_req = 1; if_addr = 32'h40; flush = 1; m_ready = 0;
        tick(); #1;
        checks++;
        if ({m_req, stall_if} !== 2'b01) begin
            errors++;
            $display("FAIL flush_idle: got m_req,stall_if=%b required 01", {m_req, stall_if});
        end
        flush = 0;
        tick();
        flush = 1; #1;
        checks++;
        if ({m_req, m_addr} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL flush_grant: got m_req=%b addr=%h required 1 00000040", m_req, m_addr);
        end
        tick();
        flush = 0;
        tick();
        tick();
        m_ready = 1; m_rdata = 32'h7777_7777; #1;
        checks++;
        if ({m_req, if_ack, stall_if, if_rdata} !== {3'b101, 32'd0}) begin
            errors++;
            $display("FAIL flush_drop: got m_req=%b if_ack=%b stall_if=%b rdata=%h required 1 0 1 0",
                     m_req, if_ack, stall_if, if_rdata);
        end
        tick();
        if_addr = 32'h80; m_rdata = 32'hDEAD_BEEF; #1;
        checks++;
        if ({m_req, if_ack} !== 2'b00) begin
            errors++;
            $display("FAIL flush_back_idle: got m_req,if_ack=%b required 00", {m_req, if_ack});
        end
        tick(); #1;
        checks++;
        if ({if_ack, if_rdata, m_addr} !== {1'b1, 32'hDEADBEEF, 32'h80}) begin
            errors++;
            $display("FAIL flush_next_fetch: got if_ack=%b rdata=%h addr=%h required 1 deadbeef 00000080",
                     if_ack, if_rdata, m_addr);
        end
        if_req = 0;
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        d_req = 1; d_we = 0; d_addr = 32'h20; d_loadcntrl = 5'b00100; m_ready = 0; m_rdata = 32'hFFFF_FFFF;
        repeat (4) tick();
        #1;
        checks++;
        if ({m_req, d_ack, bus_err} !== 3'b100) begin
            errors++;
            $display("FAIL tmo_wait4: got m_req,d_ack,err=%b required 100", {m_req, d_ack, bus_err});
        end
        tick(); #1;
        checks++;
        if ({m_req, d_ack, bus_err, d_rdata} !== {3'b011, 32'd0}) begin
            errors++;
            $display("FAIL tmo_ack: got m_req=%b d_ack=%b err=%b rdata=%h required 0 1 1 0", m_req, d_ack, bus_err, d_rdata);
        end
        d_req = 0;
        tick();
        checks++;
        if ({m_req, d_ack, bus_err} !== 3'b000) begin
            errors++;
            $display("FAIL tmo_idle: got %b required 000", {m_req, d_ack, bus_err});
        end
        d_loadcntrl = 0;
    endtask
`else
    task automatic test_long_wait();
        d_req = 1; d_we = 0; d_addr = 32'h20; d_loadcntrl = 5'b00100; m_ready = 0; m_rdata = 32'h0BAD_F00D;
        repeat (8) tick();
        #1;
        checks++;
        if ({m_req, d_ack, bus_err, stall_d} !== 4'b1001) begin
            errors++;
            $display("FAIL long_wait: got m_req,d_ack,err,stall_d=%b required 1001", {m_req, d_ack, bus_err, stall_d});
        end
        m_ready = 1; #1;
        checks++;
        if ({d_ack, bus_err, d_rdata} !== {2'b10, 32'h0BADF00D}) begin
            errors++;
            $display("FAIL long_wait_ack: got d_ack=%b err=%b rdata=%h required 1 0 0badf00d", d_ack, bus_err, d_rdata);
        end
        tick();
        d_req = 0; d_loadcntrl = 0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h1234_5678; d_storecntrl = 3'b100; m_ready = 0;
        tick(); #1;
        checks++;
        if ({m_req, m_be} !== 5'b11111) begin
            errors++;
            $display("FAIL midrst_busy: got m_req,m_be=%b required 11111", {m_req, m_be});
        end
        rst = 1; #1;
        checks++;
        if ({m_req, m_we, m_be, d_ack, bus_err, m_addr, m_wdata} !== 72'd0) begin
            errors++;
            $display("FAIL midrst_clear: got req=%b we=%b be=%b ack=%b err=%b addr=%h wdata=%h required all 0",
                     m_req, m_we, m_be, d_ack, bus_err, m_addr, m_wdata);
        end
        clear_inputs();
        #1 rst = 0;
        tick(); #1;
        checks++;
        if ({m_req, d_ack} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_after: got m_req,d_ack=%b required 00", {m_req, d_ack});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_sb();
        test_store_narrow();
        test_load_align();
        test_misalign();
        test_priority();
        test_flush();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported unified memory between instruction fetch (IF) and the data access of the instruction in the MEM stage. It sequences each access over a ready/valid memory handshake, generates byte enables from the decoder's one-hot storecntrl/loadcntrl, and aligns and extends load data. It raises per-requester stalls back to the pipeline and honours the pipeline flush for fetches.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT_CYCLES, 255, maximum wait for m_ready per transaction; used only with ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
if_req  in  1  fetch request; held until if_ack
if_addr  in  ADDR_W  fetch address, word aligned
if_rdata  out  32  fetched word, valid with if_ack
if_ack  out  1  one-cycle fetch completion
flush  in  1  pipeline flush; cancels or quashes the fetch
d_req  in  1  data request (memread|memwrite); held until d_ack
d_we  in  1  1 = store
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data, LSB-justified
d_storecntrl  in  3  one-hot {sw,sh,sb}
d_loadcntrl  in  5  one-hot {lhu,lbu,lw,lh,lb}
d_rdata  out  32  aligned and extended load data
d_ack  out  1  one-cycle data completion
d_misalign  out  1  with d_ack: access rejected as misaligned
bus_err  out  1  with an ack: transaction aborted by timeout
stall_if  out  1  if_req & ~if_ack
stall_d  out  1  d_req & ~d_ack
m_req  out  1  memory request, registered
m_we  out  1  registered write enable
m_addr  out  ADDR_W  registered word address, [1:0]=0
m_be  out  4  registered byte enables
m_wdata  out  32  registered, lane-replicated write data
m_rdata  in  32  memory read word
m_ready  in  1  completes the current m_req cycle

Behaviour:
- Reset: state IDLE. m_req, m_we, m_be, if_ack, d_ack, d_misalign, bus_err = 0. m_addr, m_wdata, if_rdata, d_rdata = 0. Reset mid-transaction abandons it; m_req drops immediately.
- States: IDLE, D_BUSY, IF_BUSY, D_ERR.
- IDLE:
  - If d_req is set and the access is misaligned: go to D_ERR. Misaligned means lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠0.
  - Else if d_req: go to D_BUSY and register the m_* fields.
  - Else if if_req & ~flush: go to IF_BUSY.
  - Data always has priority over fetch.
- BUSY states: m_* fields stay stable while m_req=1. On a cycle with m_ready=1, the ack is combinational in that same cycle (if_ack or d_ack) and the next state is IDLE. m_req is low in IDLE. Minimum latency: request at cycle N gives ack at cycle N+1.
- D_ERR: d_ack=1 and d_misalign=1 for one cycle, d_rdata=0, no memory access, then IDLE.
- Byte enables:
  - sb: 0001 << addr[1:0].
  - sh: 0011 << {addr[1],0}.
  - sw and all loads: 1111.
  - m_wdata replicates the byte or halfword across all lanes.
- Load data: select the lane by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Flush:
  - In IDLE, if_req is ignored while flush=1.
  - In IF_BUSY, the bus transaction completes, but if_ack is suppressed for the whole remaining transaction (sticky drop flag cleared in IDLE).
  - Flush never affects data transactions.
- Simultaneous if_req and d_req in IDLE: data is granted; IF waits with stall_if=1.
- An illegal (all-zero) cntrl with d_req behaves as a word access.

Optional Feature:
ARB_TIMEOUT_EN:
- Compiled in: a counter resets on each grant and increments while m_req & ~m_ready. When it reaches TIMEOUT_CYCLES, m_req drops, the owner receives its ack with bus_err=1 and zero data, and the state returns to IDLE.
- Compiled out: the arbiter waits indefinitely, bus_err is tied to 0, and no counter is built.

Decomposition:
Package riscv_mem_pkg holds:
- arb_state_t enum
- bit-index constants for the storecntrl/loadcntrl one-hots
- the byte-enable lookup function

One sub-module, load_align: combinational lane select and extension, shared with the verification model.

Test Plan:
- Store sb, d_addr=0x103, d_wdata=0xAB, m_ready on the first cycle → m_be=1000, m_wdata=0xABABABAB, m_addr=0x100, d_ack at cycle N+1.
- Load lh, addr 0x202, m_rdata=0x8001_1234 → d_rdata=0xFFFF_8001. Load lhu, same address → 0x0000_8001.
- if_req and d_req both rise at cycle 0 → data is granted first. The fetch is issued only after d_ack. stall_if=1 throughout.
- Fetch granted, flush pulses for 1 cycle, m_ready after 3 wait cycles → no if_ack. The next if_req is serviced normally.
- lw at 0x0000_0006 → d_ack=1 and d_misalign=1 at cycle 1, m_req never asserted.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, m_ready held low → ack with bus_err=1 after 4 wait cycles, m_req=0, then IDLE. Assert reset mid-transaction → all outputs 0 immediately.
